// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer for the 4-bit ALU: steps A, B, opcode on a "next" button,
// drives registered ALU inputs and captures the ALU result with carry/zero for a bounded time.
module alu_operand_sequencer #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SHOW_CYCLES = 100000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_data,
   input  logic [2:0]       sw_op,
   input  logic             btn_next,
   input  logic             btn_clr,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_m,
   output logic [1:0]       op_sel,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
   output logic             result_zero,
   output logic             result_valid,
   output logic [2:0]       state_o
);

   localparam int unsigned CNT_W = $clog2(SHOW_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GOT_A = 3'd1,
      GOT_B = 3'd2,
      EXEC  = 3'd3,
      SHOW  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic               btn_prev_q;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               op_m_q, op_m_d;
   logic [1:0]         op_sel_q, op_sel_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               step_c;
   logic               timeout_c;

   // Rising edge of the debounced button; btn_prev resets high so a held button never steps.
   assign step_c    = btn_next & ~btn_prev_q;
   assign timeout_c = (cnt_q == CNT_W'(SHOW_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         btn_prev_q <= 1'b1;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_m_q     <= 1'b0;
         op_sel_q   <= 2'b00;
         result_q   <= '0;
         cout_q     <= 1'b0;
         zero_q     <= 1'b0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         btn_prev_q <= btn_next;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_m_q     <= op_m_d;
         op_sel_q   <= op_sel_d;
         result_q   <= result_d;
         cout_q     <= cout_d;
         zero_q     <= zero_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_m_d   = op_m_q;
      op_sel_d = op_sel_q;
      result_d = result_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;

      // Clear aborts the sequence but keeps the last captured result visible on the flags.
      if (btn_clr) begin
         state_d  = IDLE;
         op_a_d   = '0;
         op_b_d   = '0;
         op_m_d   = 1'b0;
         op_sel_d = 2'b00;
         valid_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (step_c) begin
                  op_a_d  = sw_data;
                  state_d = GOT_A;
               end
            end
            GOT_A: begin
               if (step_c) begin
                  op_b_d  = sw_data;
                  state_d = GOT_B;
               end
            end
            GOT_B: begin
               if (step_c) begin
                  {op_m_d, op_sel_d} = sw_op;
                  state_d            = EXEC;
               end
            end
            EXEC: begin
               result_d = alu_res;
               cout_d   = alu_cout;
               zero_d   = (alu_res == '0);
               valid_d  = 1'b1;
               cnt_d    = '0;
               state_d  = SHOW;
            end
            SHOW: begin
               // A new entry takes precedence over the display timeout.
               if (step_c) begin
                  op_a_d  = sw_data;
                  valid_d = 1'b0;
                  state_d = GOT_A;
               end else if (timeout_c) begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d  = IDLE;
               op_a_d   = '0;
               op_b_d   = '0;
               op_m_d   = 1'b0;
               op_sel_d = 2'b00;
               valid_d  = 1'b0;
            end
         endcase
      end
   end

   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign op_m         = op_m_q;
   assign op_sel       = op_sel_q;
   assign result       = result_q;
   assign result_cout  = cout_q;
   assign result_zero  = zero_q;
   assign result_valid = valid_q;
   assign state_o      = 3'(state_q);

endmodule
